// File: rtl/ar9331_to_fpga.sv
// Receive side of the AR9331 byte link: synchronizes the four-phase strobe/ack
// handshake into clk, buffers bytes in a show-ahead FIFO and streams them out.
module ar9331_to_fpga #(
   parameter int DEPTH   = 16,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [LEN_W-1:0] len_in,
   input  logic             strb_in,
   input  logic [7:0]       data_in,
   output logic             ack,
   output logic [7:0]       dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             frame_done,
   output logic [4:0]       status
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_HI = 3'd1,
      WAIT_LO = 3'd2,
      DONE    = 3'd3,
      ERR     = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic             strb_meta, strb_s;
   logic [7:0]       data_meta, data_s;
   logic             ack_nx, err, err_nx;
   logic [LEN_W-1:0] len_lat, len_nx, byte_cnt, cnt_nx;
   logic [TW-1:0]    tmo_cnt, tmo_nx;
   logic             push, pop, fifo_full;
   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      occ;

   // Two-flop synchronizers; the data bus is held stable by the host across the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb_meta <= 1'b0;
         strb_s    <= 1'b0;
         data_meta <= 8'h00;
         data_s    <= 8'h00;
      end else begin
         strb_meta <= strb_in;
         strb_s    <= strb_meta;
         data_meta <= data_in;
         data_s    <= data_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ack      <= 1'b0;
         err      <= 1'b0;
         len_lat  <= '0;
         byte_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         state    <= state_nx;
         ack      <= ack_nx;
         err      <= err_nx;
         len_lat  <= len_nx;
         byte_cnt <= cnt_nx;
         tmo_cnt  <= tmo_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ack_nx   = ack;
      err_nx   = err;
      len_nx   = len_lat;
      cnt_nx   = byte_cnt;
      tmo_nx   = tmo_cnt;
      push     = 1'b0;
      if (!en) begin
         state_nx = IDLE;
         ack_nx   = 1'b0;
         err_nx   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ack_nx = 1'b0;
               if (len_in != '0) begin
                  len_nx   = len_in;
                  cnt_nx   = '0;
                  state_nx = WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (strb_s && !fifo_full) begin
                  push     = 1'b1;
                  cnt_nx   = byte_cnt + 1'b1;
                  ack_nx   = 1'b1;
                  tmo_nx   = '0;
                  state_nx = WAIT_LO;
               end
            end
            WAIT_LO: begin
               // The TIMEOUT-th cycle spent here without a strobe fall is fatal.
               if (!strb_s) begin
                  ack_nx   = 1'b0;
                  state_nx = (byte_cnt == len_lat) ? DONE : WAIT_HI;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  ack_nx   = 1'b0;
                  err_nx   = 1'b1;
                  state_nx = ERR;
               end else begin
                  tmo_nx = tmo_cnt + 1'b1;
               end
            end
            DONE:    state_nx = IDLE;
            ERR:     ack_nx   = 1'b0;
            default: state_nx = IDLE;
         endcase
      end
   end

   assign pop        = dout_valid & dout_ready;
   assign fifo_full  = (occ == (AW + 1)'(DEPTH));
   assign dout_valid = (occ != '0);
   assign dout       = mem[rd_ptr];
   assign frame_done = (state == DONE);
   assign status     = {err, fifo_full, state};

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_s;
   end

   // Pointers wrap naturally at DEPTH; occupancy is one bit wider to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_ar9331_to_fpga.sv
// Directed bench for ar9331_to_fpga: table of frames plus hand-written
// backpressure, timeout, abort, zero-length and reset sequences.
module tb_ar9331_to_fpga;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] len_in;
   logic        strb_in;
   logic [7:0]  data_in;
   logic        ack;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        frame_done;
   logic [4:0]  status;

   int          total;
   int          bad;
   int          done_cnt;
   int          chk_idx;
   logic [7:0]  got [$];
   logic [7:0]  exp [$];

   typedef struct {
      int              len;
      logic [3:0][7:0] bytes;
   } frame_t;

   frame_t tbl [4];

   ar9331_to_fpga #(.DEPTH(16), .LEN_W(16), .TIMEOUT(1000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .len_in     (len_in),
      .strb_in    (strb_in),
      .data_in    (data_in),
      .ack        (ack),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_done (frame_done),
      .status     (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor samples on the falling edge, midway between active edges.
   always @(negedge clk) begin
      if (rst_n && frame_done) done_cnt++;
      if (rst_n && dout_valid && dout_ready) got.push_back(dout);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int act, input int want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full four-phase handshake for one byte, checking both 3-edge latencies.
   task automatic sendByte(input logic [7:0] b);
      int n;
      data_in = b;
      tick(2);
      strb_in = 1'b1;
      n = 0;
      do begin tick(1); n++; end while (!ack && n < 40);
      checkOutput("ack_rise_lat", n, 3);
      strb_in = 1'b0;
      n = 0;
      do begin tick(1); n++; end while (ack && n < 40);
      checkOutput("ack_fall_lat", n, 3);
   endtask

   task automatic checkData(input string name);
      tick(3);
      checkOutput({name, "_count"}, got.size(), exp.size());
      while (chk_idx < exp.size() && chk_idx < got.size()) begin
         checkOutput({name, "_byte"}, int'(got[chk_idx]), int'(exp[chk_idx]));
         chk_idx++;
      end
      chk_idx = exp.size();
   endtask

   // Sends one table frame; len_in is moved on to the next frame right after the last byte.
   task automatic applyStimulus(input int idx);
      int d0;
      d0 = done_cnt;
      for (int k = 0; k < tbl[idx].len; k++) begin
         exp.push_back(tbl[idx].bytes[k]);
         sendByte(tbl[idx].bytes[k]);
         if (k < tbl[idx].len - 1) checkOutput("no_early_done", done_cnt - d0, 0);
      end
      len_in = (idx < 3) ? 16'(tbl[idx + 1].len) : 16'd0;
      checkData("frame_data");
      checkOutput("frame_done_pulses", done_cnt - d0, 1);
   endtask

   initial begin
      int n;
      int d0;
      int hits;
      total = 0; bad = 0; done_cnt = 0; chk_idx = 0;
      rst_n = 1'b0; en = 1'b0; len_in = 16'd0; strb_in = 1'b0;
      data_in = 8'h00; dout_ready = 1'b1;

      tbl[0].len = 4; tbl[0].bytes = {8'h44, 8'h33, 8'h22, 8'h11};
      tbl[1].len = 1; tbl[1].bytes = {8'h00, 8'h00, 8'h00, 8'hA5};
      tbl[2].len = 1; tbl[2].bytes = {8'h00, 8'h00, 8'h00, 8'h5A};
      tbl[3].len = 2; tbl[3].bytes = {8'h00, 8'h00, 8'hFF, 8'h00};

      tick(3);
      checkOutput("reset_ack", ack, 0);
      checkOutput("reset_status", status, 0);
      checkOutput("reset_valid", dout_valid, 0);
      checkOutput("reset_done", frame_done, 0);
      #2 rst_n = 1'b1;
      tick(2);

      $display("[TB] table frames, including back-to-back len=1");
      len_in = 16'(tbl[0].len);
      en = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(i);
      tick(2);
      checkOutput("frames_end_status", status, 0);
      en = 1'b0;
      tick(2);

      $display("[TB] backpressure");
      dout_ready = 1'b0;
      len_in = 16'd20;
      en = 1'b1;
      d0 = done_cnt;
      for (int k = 0; k < 16; k++) begin
         exp.push_back(8'(k * 7 + 3));
         sendByte(8'(k * 7 + 3));
      end
      checkOutput("bp_full_status", status, 5'b01001);
      exp.push_back(8'hC7);
      data_in = 8'hC7;
      tick(2);
      strb_in = 1'b1;
      tick(8);
      checkOutput("bp_held_ack", ack, 0);
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
      checkOutput("bp_no_push_on_pop_edge", ack, 0);
      tick(1);
      checkOutput("bp_push_after_pop", ack, 1);
      strb_in = 1'b0;
      n = 0;
      do begin tick(1); n++; end while (ack && n < 40);
      checkOutput("bp_ack_fall", ack, 0);
      dout_ready = 1'b1;
      for (int k = 17; k < 20; k++) begin
         exp.push_back(8'(k * 7 + 3));
         sendByte(8'(k * 7 + 3));
      end
      tick(20);
      checkData("bp_data");
      checkOutput("bp_done_pulses", done_cnt - d0, 1);
      en = 1'b0;
      tick(2);

      $display("[TB] timeout");
      len_in = 16'd2;
      en = 1'b1;
      exp.push_back(8'h9E);
      data_in = 8'h9E;
      tick(2);
      strb_in = 1'b1;
      n = 0;
      do begin tick(1); n++; end while (!ack && n < 40);
      checkOutput("tmo_ack_rise", n, 3);
      tick(999);
      checkOutput("tmo_before_status", status, 5'b00010);
      checkOutput("tmo_before_ack", ack, 1);
      tick(1);
      checkOutput("tmo_status", status, 5'b10100);
      checkOutput("tmo_ack", ack, 0);
      strb_in = 1'b0;
      tick(3);
      checkOutput("tmo_err_hold", status, 5'b10100);
      en = 1'b0;
      tick(1);
      checkOutput("tmo_cleared", status, 0);
      checkData("tmo_data");

      $display("[TB] abort after 2 of 5 bytes");
      dout_ready = 1'b0;
      len_in = 16'd5;
      en = 1'b1;
      d0 = done_cnt;
      exp.push_back(8'h01); sendByte(8'h01);
      exp.push_back(8'h02); sendByte(8'h02);
      en = 1'b0;
      tick(1);
      checkOutput("abort_ack", ack, 0);
      checkOutput("abort_state", status[2:0], 0);
      checkOutput("abort_valid", dout_valid, 1);
      dout_ready = 1'b1;
      tick(3);
      checkOutput("abort_no_done", done_cnt - d0, 0);
      checkData("abort_data");

      $display("[TB] zero length");
      len_in = 16'd0;
      en = 1'b1;
      data_in = 8'h77;
      tick(2);
      strb_in = 1'b1;
      hits = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (ack || status != 5'd0) hits++;
      end
      strb_in = 1'b0;
      checkOutput("zero_len_idle", hits, 0);
      checkOutput("zero_len_valid", dout_valid, 0);
      en = 1'b0;
      tick(2);

      $display("[TB] reset mid-handshake");
      dout_ready = 1'b0;
      len_in = 16'd3;
      en = 1'b1;
      data_in = 8'hE1;
      tick(2);
      strb_in = 1'b1;
      n = 0;
      do begin tick(1); n++; end while (!ack && n < 40);
      checkOutput("rst_ack_before", ack, 1);
      checkOutput("rst_valid_before", dout_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_ack", ack, 0);
      checkOutput("rst_valid", dout_valid, 0);
      checkOutput("rst_status", status, 0);
      strb_in = 1'b0;
      en = 1'b0;
      #10 rst_n = 1'b1;
      tick(2);
      checkOutput("rst_fifo_empty", dout_valid, 0);
      checkOutput("rst_status_after", status, 0);

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
